// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam int WMASK_W = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/LSU front-ends, the arbiter and the memory wrapper.
// The arbiter uses the slave modport; the environment that drives it uses master.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic               ifu_req_valid;
    logic               ifu_req_ready;
    logic [ADDR_W-1:0]  ifu_addr;
    logic               ifu_resp_valid;
    logic [DATA_W-1:0]  ifu_rdata;

    logic               lsu_req_valid;
    logic               lsu_req_ready;
    logic [ADDR_W-1:0]  lsu_addr;
    logic               lsu_wen;
    logic [DATA_W-1:0]  lsu_wdata;
    logic [WMASK_W-1:0] lsu_wmask;
    logic               lsu_resp_valid;
    logic [DATA_W-1:0]  lsu_rdata;

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_wen;
    logic [DATA_W-1:0]  mem_wdata;
    logic [WMASK_W-1:0] mem_wmask;
    logic               mem_resp_valid;
    logic [DATA_W-1:0]  mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between IFU and LSU.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise LSU has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic last,
    output logic grant,
    output logic any_valid
);

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        any_valid = ifu_valid | lsu_valid;
        grant     = OWN_IFU;
`ifdef MEM_ARB_RR_EN
        if (ifu_valid && lsu_valid) begin
            grant = ~last;
        end else if (lsu_valid) begin
            grant = OWN_LSU;
        end
`else
        if (lsu_valid) begin
            grant = OWN_LSU;
        end
`endif
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority never looks at the previous grant.
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IFU and LSU requests onto the single memory port, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is LSU-first fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_t             state;
    logic               owner_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               wen_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [WMASK_W-1:0] wmask_q;
    logic               mem_req_valid_q;
    logic               ifu_resp_valid_q;
    logic               lsu_resp_valid_q;
    logic [DATA_W-1:0]  ifu_rdata_q;
    logic [DATA_W-1:0]  lsu_rdata_q;

    logic grant;
    logic any_valid;
    logic accept;
    logic last_grant;

`ifdef MEM_ARB_RR_EN
    logic last_q;
    assign last_grant = last_q;
`else
    assign last_grant = OWN_IFU;
`endif

    mem_arb_pick u_pick (
        .ifu_valid (bus.ifu_req_valid),
        .lsu_valid (bus.lsu_req_valid),
        .last      (last_grant),
        .grant     (grant),
        .any_valid (any_valid)
    );

    assign accept = (state == IDLE) && any_valid;

    assign bus.ifu_req_ready = (state == IDLE) && bus.ifu_req_valid && (grant == OWN_IFU);
    assign bus.lsu_req_ready = (state == IDLE) && bus.lsu_req_valid && (grant == OWN_LSU);

    assign bus.mem_req_valid  = mem_req_valid_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;
    assign bus.ifu_resp_valid = ifu_resp_valid_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.lsu_resp_valid = lsu_resp_valid_q;
    assign bus.lsu_rdata      = lsu_rdata_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            owner_q          <= OWN_IFU;
            addr_q           <= '0;
            wen_q            <= 1'b0;
            wdata_q          <= '0;
            wmask_q          <= '0;
            mem_req_valid_q  <= 1'b0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= '0;
            lsu_rdata_q      <= '0;
`ifdef MEM_ARB_RR_EN
            last_q           <= OWN_IFU;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner_q         <= grant;
                        mem_req_valid_q <= 1'b1;
                        state           <= REQ;
`ifdef MEM_ARB_RR_EN
                        last_q          <= grant;
`endif
                        if (grant == OWN_LSU) begin
                            addr_q  <= bus.lsu_addr;
                            wen_q   <= bus.lsu_wen;
                            wdata_q <= bus.lsu_wdata;
                            wmask_q <= bus.lsu_wmask;
                        end else begin
                            // Instruction fetch is always a plain read.
                            addr_q  <= bus.ifu_addr;
                            wen_q   <= 1'b0;
                            wdata_q <= '0;
                            wmask_q <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        state <= RESP;
                        if (owner_q == OWN_LSU) begin
                            lsu_rdata_q      <= wen_q ? '0 : bus.mem_rdata;
                            lsu_resp_valid_q <= 1'b1;
                        end else begin
                            ifu_rdata_q      <= bus.mem_rdata;
                            ifu_resp_valid_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    ifu_resp_valid_q <= 1'b0;
                    lsu_resp_valid_q <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences and random traffic.
// Expected grants follow MEM_ARB_RR_EN the same way the design build does.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef MEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    typedef struct {
        logic        iv;
        logic        lv;
        logic        wen;
        logic [31:0] ia;
        logic [31:0] la;
        logic [31:0] wd;
        logic [7:0]  wm;
        logic [31:0] rd;
        int          s1;
        int          s2;
        logic        spur;
        logic        exp_own;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        rr_last;
    logic [31:0] exp_ifu_rd;
    logic [31:0] exp_lsu_rd;
    vec_t        vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Reference pick rule: single requester wins; ties go to LSU, or alternate under round-robin.
    function automatic logic model_pick(input logic iv, input logic lv);
        if (iv && lv) return RR_MODE ? ~rr_last : OWN_LSU;
        return lv ? OWN_LSU : OWN_IFU;
    endfunction

    function automatic vec_t mk(input logic iv, input logic lv, input logic wen,
                                input logic [31:0] ia, input logic [31:0] la,
                                input logic [31:0] wd, input logic [7:0] wm,
                                input logic [31:0] rd, input int s1, input int s2,
                                input logic spur, input logic exp_own);
        vec_t v;
        v.iv = iv; v.lv = lv; v.wen = wen; v.ia = ia; v.la = la; v.wd = wd;
        v.wm = wm; v.rd = rd; v.s1 = s1; v.s2 = s2; v.spur = spur; v.exp_own = exp_own;
        return v;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_ifu_resp_valid"}, bus.ifu_resp_valid, 0);
        check({tag, "_lsu_resp_valid"}, bus.lsu_resp_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req_valid"}, bus.mem_req_valid, 0);
        check_quiet(tag);
        check({tag, "_ifu_rdata"}, bus.ifu_rdata, 0);
        check({tag, "_lsu_rdata"}, bus.lsu_rdata, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_mem_wmask"}, {24'd0, bus.mem_wmask}, 0);
        check({tag, "_mem_wen"}, bus.mem_wen, 0);
    endtask

    // One full transaction; entered and left just after a rising edge with the arbiter idle.
    task automatic run_txn(input vec_t v);
        logic [31:0] ea;
        logic        ewen;
        logic [7:0]  ewm;
        ea   = (v.exp_own == OWN_LSU) ? v.la : v.ia;
        ewen = (v.exp_own == OWN_LSU) ? v.wen : 1'b0;
        ewm  = (v.exp_own == OWN_LSU) ? v.wm : 8'h00;

        bus.ifu_req_valid = v.iv;
        bus.ifu_addr      = v.ia;
        bus.lsu_req_valid = v.lv;
        bus.lsu_addr      = v.la;
        bus.lsu_wen       = v.wen;
        bus.lsu_wdata     = v.wd;
        bus.lsu_wmask     = v.wm;
        sample();
        check("ifu_req_ready", bus.ifu_req_ready, v.iv && (v.exp_own == OWN_IFU));
        check("lsu_req_ready", bus.lsu_req_ready, v.lv && (v.exp_own == OWN_LSU));
        step();
        rr_last           = v.exp_own;
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.ifu_addr      = $urandom;
        bus.lsu_addr      = $urandom;
        bus.lsu_wen       = 1'($urandom);
        bus.lsu_wdata     = $urandom;
        bus.lsu_wmask     = 8'($urandom);

        for (int i = 0; i <= v.s1; i++) begin
            bus.mem_req_ready  = (i == v.s1);
            bus.mem_resp_valid = (i == v.s1) ? 1'b0 : v.spur;
            bus.mem_rdata      = $urandom;
            sample();
            check("req_valid", bus.mem_req_valid, 1);
            check("req_addr", bus.mem_addr, ea);
            check("req_wen", bus.mem_wen, ewen);
            check("req_wmask", {24'd0, bus.mem_wmask}, {24'd0, ewm});
            if (v.exp_own == OWN_LSU) check("req_wdata", bus.mem_wdata, v.wd);
            check_quiet("req");
            step();
        end
        bus.mem_req_ready = 1'b0;

        for (int i = 0; i < v.s2; i++) begin
            bus.mem_resp_valid = 1'b0;
            sample();
            check("wait_req_valid", bus.mem_req_valid, 0);
            check_quiet("wait");
            step();
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = v.rd;
        sample();
        check_quiet("wait_last");
        step();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = $urandom;

        if (v.exp_own == OWN_LSU) exp_lsu_rd = v.wen ? 32'd0 : v.rd;
        else                      exp_ifu_rd = v.rd;
        sample();
        check("resp_ifu_valid", bus.ifu_resp_valid, v.exp_own == OWN_IFU);
        check("resp_lsu_valid", bus.lsu_resp_valid, v.exp_own == OWN_LSU);
        check("resp_ifu_rdata", bus.ifu_rdata, exp_ifu_rd);
        check("resp_lsu_rdata", bus.lsu_rdata, exp_lsu_rd);
        step();
        sample();
        check_quiet("after");
        check("hold_ifu_rdata", bus.ifu_rdata, exp_ifu_rd);
        check("hold_lsu_rdata", bus.lsu_rdata, exp_lsu_rd);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int          acc_cyc[$];
        logic [31:0] seen_addr[$];
        int          k;
        vec_t        rv;

        rst = 1'b0;
        bus.ifu_req_valid  = 1'b0;
        bus.ifu_addr       = '0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_addr       = '0;
        bus.lsu_wen        = 1'b0;
        bus.lsu_wdata      = '0;
        bus.lsu_wmask      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        rr_last    = OWN_IFU;
        exp_ifu_rd = '0;
        exp_lsu_rd = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        step();

        // Directed vectors: IFU read, four ties, store with stalls, stalled load with spurious pulses.
        vecs[0] = mk(1, 0, 0, 32'h8000_0000, 32'h0, 32'h0, 8'h00, 32'h0010_0073, 0, 0, 0, OWN_IFU);
        for (int t = 0; t < 4; t++) begin
            vecs[1+t] = mk(1, 1, 0, 32'h8000_0100 + 32'(t*4), 32'h8000_2000 + 32'(t*4),
                           32'h0, 8'h00, 32'hA000_0000 + 32'(t),
                           0, 0, 0, (RR_MODE && (t % 2 == 1)) ? OWN_IFU : OWN_LSU);
        end
        vecs[5] = mk(0, 1, 1, 32'h0, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 32'h1234_5678, 3, 0, 0, OWN_LSU);
        vecs[6] = mk(0, 1, 0, 32'h0, 32'h8000_3000, 32'h0, 8'h00, 32'hCAFE_F00D, 2, 2, 1, OWN_LSU);
        vecs[7] = mk(1, 0, 0, 32'h8000_0040, 32'h0, 32'h0, 8'h00, 32'h0000_0013, 0, 1, 0, OWN_IFU);
        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Spurious responses while idle leave the arbiter idle and silent.
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h5555_5555;
        for (int i = 0; i < 2; i++) begin
            sample();
            check_quiet("idle_spur");
            check("idle_spur_req_valid", bus.mem_req_valid, 0);
            step();
        end
        bus.mem_resp_valid = 1'b0;
        sample();
        check_quiet("idle_spur_end");
        check("idle_spur_ifu_rdata", bus.ifu_rdata, exp_ifu_rd);
        step();
        run_txn(mk(1, 0, 0, 32'h8000_0080, 32'h0, 32'h0, 8'h00, 32'h0000_0093, 0, 0, 0, OWN_IFU));

        // Back-to-back fetches against a zero-stall slave.
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_1111;
        bus.ifu_req_valid  = 1'b1;
        bus.ifu_addr       = 32'h8000_0000;
        k = 0;
        for (int c = 0; c < 14; c++) begin
            logic acc;
            sample();
            acc = bus.ifu_req_ready;
            if (acc) acc_cyc.push_back(c);
            if (bus.mem_req_valid) seen_addr.push_back(bus.mem_addr);
            step();
            if (acc) begin
                k++;
                bus.ifu_addr = 32'h8000_0000 + 32'(k*4);
            end
        end
        bus.ifu_req_valid = 1'b0;
        step();
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready  = 1'b0;
        step();
        rr_last    = OWN_IFU;
        exp_ifu_rd = 32'h0000_1111;
        check("b2b_accept_count", acc_cyc.size(), 4);
        check("b2b_addr_count", seen_addr.size(), 4);
        for (int i = 0; i < acc_cyc.size() && i < 4; i++) check("b2b_accept_cycle", acc_cyc[i], i * 4);
        for (int i = 0; i < seen_addr.size() && i < 4; i++)
            check("b2b_addr", seen_addr[i], 32'h8000_0000 + 32'(i*4));
        sample();
        check("b2b_ifu_rdata", bus.ifu_rdata, exp_ifu_rd);
        check_quiet("b2b_end");
        step();

        // Random traffic against the pick rule and transaction-level expectations.
        for (int n = 0; n < 40; n++) begin
            rv.iv = 1'($urandom);
            rv.lv = 1'($urandom);
            if (!rv.iv && !rv.lv) rv.iv = 1'b1;
            rv.wen  = 1'($urandom);
            rv.ia   = $urandom;
            rv.la   = $urandom;
            rv.wd   = $urandom;
            rv.wm   = 8'($urandom);
            rv.rd   = $urandom;
            rv.s1   = int'($urandom_range(0, 2));
            rv.s2   = int'($urandom_range(0, 2));
            rv.spur = 1'($urandom);
            rv.exp_own = model_pick(rv.iv, rv.lv);
            run_txn(rv);
        end

        // Reset while an LSU load waits for its response.
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_4000;
        bus.lsu_wen       = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.lsu_req_valid = 1'b0;
        step();
        bus.mem_req_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        rr_last    = OWN_IFU;
        exp_ifu_rd = '0;
        exp_lsu_rd = '0;
        @(negedge clk);
        rst = 1'b1;
        step();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0BAD_0BAD;
        for (int i = 0; i < 4; i++) begin
            sample();
            check_quiet("post_reset");
            check("post_reset_req_valid", bus.mem_req_valid, 0);
            check("post_reset_lsu_rdata", bus.lsu_rdata, 0);
            step();
        end
        bus.mem_resp_valid = 1'b0;
        run_txn(mk(1, 1, 0, 32'h8000_5000, 32'h8000_6000, 32'h0, 8'h00, 32'h7777_0000, 0, 0, 0, OWN_LSU));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the single `pmem_read`/`pmem_write` memory port between instruction fetch (IFU) and load/store (LSU). It is placed between the fetch/LSU front-ends and the memory wrapper. This replaces the current arrangement, where `inst` and load/store data reach memory through independent, always-ready DPI calls. The block serialises requests with valid/ready handshakes, tracks the single outstanding transaction, and routes each response back to its owner.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `ifu_req_valid` in 1 / `ifu_req_ready` out 1 / `ifu_addr` in ADDR_W: fetch request
- `ifu_resp_valid` out 1 / `ifu_rdata` out DATA_W: fetch response, single-cycle pulse
- `lsu_req_valid` in 1 / `lsu_req_ready` out 1 / `lsu_addr` in ADDR_W: LSU request
- `lsu_wen` in 1 / `lsu_wdata` in DATA_W / `lsu_wmask` in 8: LSU store controls
- `lsu_resp_valid` out 1 / `lsu_rdata` out DATA_W: LSU response, single-cycle pulse
- `mem_req_valid` out 1 / `mem_req_ready` in 1: slave request handshake
- `mem_addr` out ADDR_W / `mem_wen` out 1 / `mem_wdata` out DATA_W / `mem_wmask` out 8: slave request payload
- `mem_resp_valid` in 1 / `mem_rdata` in DATA_W: slave response

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Exactly one transaction is outstanding at any time.
- IDLE: the pick logic chooses one valid master. Only the chosen master sees `*_req_ready=1`; `*_req_ready` is combinational and equals IDLE & own valid & chosen.
  - On acceptance, capture addr/wen/wdata/wmask and owner into registers, then go to REQ.
  - IFU requests are always captured with wen=0 and wmask=0.
- REQ: `mem_req_valid=1` and the payload comes from the capture registers. On `mem_req_ready` go to WAIT. The payload is held stable while stalled.
- WAIT: on `mem_resp_valid`, register `mem_rdata` into the owner's rdata and go to RESP. `mem_resp_valid` is ignored in IDLE, REQ and RESP.
- RESP: the owner's `*_resp_valid=1` for exactly one cycle, then IDLE. Stores also pulse `lsu_resp_valid`, with `lsu_rdata=0`.
- There is no response back-pressure; masters must sink the pulse.
- The non-owner's `*_resp_valid` is never asserted. `*_rdata` holds its last value outside the pulse.
- Both masters valid in IDLE: resolved by the pick rule (see Configuration).
- A master dropping valid before acceptance is legal; nothing is captured.

## Timing
- Reset (`rst`=0, asynchronous) puts the FSM in IDLE.
  - All outputs are 0: `mem_req_valid`, both resp_valid, both rdata, `mem_addr`/`mem_wdata`/`mem_wmask`/`mem_wen`.
  - The RR pointer is reset to "last=IFU".
- Reset mid-transaction abandons the transaction. No response is issued after reset release.
- Minimum latency:
  - Acceptance edge at cycle 0.
  - `mem_req_valid` high in cycle 1.
  - `mem_req_ready` in cycle 1 gives WAIT in cycle 2.
  - `mem_resp_valid` in cycle 2 gives `*_resp_valid` in cycle 3.
- Next acceptance can happen in cycle 4, so throughput is at most 1 transaction per 4 cycles.
- Each slave stall cycle, in REQ or WAIT, adds exactly one cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, the master not granted last wins.
  - The pointer updates only on acceptance. After reset, LSU wins the first tie.
- `MEM_ARB_RR_EN` undefined: fixed priority, LSU always beats IFU. There is no pointer register.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/REQ/WAIT/RESP);
  - owner encoding `OWN_IFU=1'b0`, `OWN_LSU=1'b1`;
  - the `WMASK_W=8` constant.
- Sub-module `mem_arb_pick` is combinational: it takes the two valids and the last-grant bit, and outputs the grant bit and an any-valid flag. It contains the `MEM_ARB_RR_EN` logic.
- The FSM, capture registers and response routing live in `mem_arbiter`.

## Test plan
- IFU-only read:
  - Stimulus: `ifu_addr=0x80000000`, slave always ready, `mem_rdata=0x00100073`, response 1 cycle after the request.
  - Expected: `ifu_resp_valid` in cycle 3 with `ifu_rdata=0x00100073`, and `lsu_resp_valid` never set.
- LSU store:
  - Stimulus: addr `0x80001000`, wdata `0xDEADBEEF`, wmask `0x0F`.
  - Expected: `mem_wen=1` and the payload held while `mem_req_ready` is low for 3 cycles. `lsu_resp_valid` pulses once, with `lsu_rdata=0`.
- Simultaneous valid, repeated 4 times:
  - Fixed priority: grants LSU, LSU, LSU, LSU.
  - With `MEM_ARB_RR_EN`: grants LSU, IFU, LSU, IFU.
- Spurious responses:
  - Stimulus: `mem_resp_valid` pulsed in IDLE and in REQ.
  - Expected: no resp_valid on either master, and the FSM state is unchanged.
- Reset in WAIT:
  - Stimulus: drop `rst` mid-WAIT, then assert `mem_resp_valid` after reset release.
  - Expected: all outputs are 0 immediately, and no response pulse is issued afterwards.
- Back-to-back IFU requests:
  - Stimulus: `ifu_req_valid` held high, zero-stall slave.
  - Expected: acceptances exactly 4 cycles apart, and addresses are captured in order.
